gesture_sampler: RTL and testbench

GESTURE_SAMPLER -- requirements
Module: gesture_sampler

---
 rtl/gesture_sampler_pkg.sv | 23 ++
 rtl/gesture_run_counter.sv | 42 ++++
 rtl/gesture_sampler.sv | 126 ++++++++++++
 tb/tb_gesture_sampler.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/gesture_sampler_pkg.sv
// Shared gesture and sampler-state encodings, used by the sampler and the game controller.
package gesture_sampler_pkg;

  typedef enum logic [1:0] {
    G_SCISSORS = 2'b00,
    G_PAPER    = 2'b01,
    G_ROCK     = 2'b10,
    G_NONE     = 2'b11
  } gesture_t;

  typedef enum logic [1:0] {
    ST_COUNTDOWN = 2'b00,
    ST_CAPTURE   = 2'b01,
    ST_RELEASE   = 2'b10
  } state_t;

  localparam int CNT_W = 8;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/gesture_run_counter.sv
// Candidate gesture plus saturating run length; exposes the post-frame values so the
// caller can make its lock decision in the same cycle the frame arrives.
module gesture_run_counter
  import gesture_sampler_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             advance,
  input  gesture_t         gesture,
  output gesture_t         cand_next,
  output logic [CNT_W-1:0] run_next
);

  gesture_t         candidate;
  logic [CNT_W-1:0] run_count;

  // A none frame breaks the run but keeps the candidate.
  always_comb begin
    cand_next = candidate;
    run_next  = run_count;
    if (gesture == G_NONE) begin
      run_next = '0;
    end else if (gesture == candidate) begin
      run_next = sat_inc(run_count);
    end else begin
      cand_next = gesture;
      run_next  = {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      candidate <= G_NONE;
      run_count <= '0;
    end else if (advance) begin
      candidate <= cand_next;
      run_count <= run_next;
    end
  end

endmodule

// File: rtl/gesture_sampler.sv
// Countdown / capture / release sequencer that turns per-frame classifier results
// into single locked gestures for the game controller.
module gesture_sampler
  import gesture_sampler_pkg::*;
#(
  parameter int unsigned STABLE_FRAMES    = 4,
  parameter int unsigned COUNTDOWN_FRAMES = 60,
  parameter int unsigned RELEASE_FRAMES   = 8,
  parameter int unsigned TIMEOUT_FRAMES   = 180
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_done,
  input  logic [1:0] raw_gesture,
  output logic [1:0] player_gesture,
  output logic       valid,
  output logic       go,
  output logic       capture_timeout,
  output logic       countdown_active,
  output logic [7:0] frames_left
);

  localparam logic [CNT_W-1:0] STABLE_N    = CNT_W'(STABLE_FRAMES);
  localparam logic [CNT_W-1:0] COUNTDOWN_N = CNT_W'(COUNTDOWN_FRAMES);
  localparam logic [CNT_W-1:0] RELEASE_N   = CNT_W'(RELEASE_FRAMES);
  localparam logic [CNT_W-1:0] TIMEOUT_N   = CNT_W'(TIMEOUT_FRAMES);

  state_t           state, state_n;
  // One frame counter serves all states: countdown remaining, capture elapsed,
  // or consecutive none frames in release.
  logic [CNT_W-1:0] frame_cnt, frame_cnt_n, cnt_inc;
  gesture_t         pg_q, pg_n, raw, cand_next;
  logic [CNT_W-1:0] run_next;
  logic             valid_n, go_n, timeout_n, rc_clear, rc_adv;

  assign raw     = gesture_t'(raw_gesture);
  assign cnt_inc = frame_cnt + 1'b1;

  gesture_run_counter u_run (
    .clk       (clk),
    .reset     (reset),
    .clear     (rc_clear),
    .advance   (rc_adv),
    .gesture   (raw),
    .cand_next (cand_next),
    .run_next  (run_next)
  );

  always_comb begin
    state_n     = state;
    frame_cnt_n = frame_cnt;
    pg_n        = pg_q;
    valid_n     = 1'b0;
    go_n        = 1'b0;
    timeout_n   = 1'b0;
    rc_clear    = 1'b0;
    rc_adv      = 1'b0;
    if (frame_done) begin
      case (state)
        ST_COUNTDOWN: begin
          if (frame_cnt <= 1) begin
            go_n        = 1'b1;
            state_n     = ST_CAPTURE;
            frame_cnt_n = '0;
            rc_clear    = 1'b1;
          end else begin
            frame_cnt_n = frame_cnt - 1'b1;
          end
        end
        ST_CAPTURE: begin
          rc_adv = 1'b1;
          // Lock is tested first so it wins a tie with the timeout.
          if (run_next == STABLE_N) begin
            pg_n        = cand_next;
            valid_n     = 1'b1;
            state_n     = ST_RELEASE;
            frame_cnt_n = '0;
          end else if (cnt_inc == TIMEOUT_N) begin
            timeout_n   = 1'b1;
            state_n     = ST_COUNTDOWN;
            frame_cnt_n = COUNTDOWN_N;
          end else begin
            frame_cnt_n = cnt_inc;
          end
        end
        ST_RELEASE: begin
          if (raw != G_NONE) begin
            frame_cnt_n = '0;
          end else if (cnt_inc == RELEASE_N) begin
            state_n     = ST_COUNTDOWN;
            frame_cnt_n = COUNTDOWN_N;
          end else begin
            frame_cnt_n = cnt_inc;
          end
        end
        default: begin
          state_n     = ST_COUNTDOWN;
          frame_cnt_n = COUNTDOWN_N;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state           <= ST_COUNTDOWN;
      frame_cnt       <= COUNTDOWN_N;
      pg_q            <= G_NONE;
      valid           <= 1'b0;
      go              <= 1'b0;
      capture_timeout <= 1'b0;
    end else begin
      state           <= state_n;
      frame_cnt       <= frame_cnt_n;
      pg_q            <= pg_n;
      valid           <= valid_n;
      go              <= go_n;
      capture_timeout <= timeout_n;
    end
  end

  assign player_gesture   = pg_q;
  assign countdown_active = (state == ST_COUNTDOWN);
  assign frames_left      = countdown_active ? frame_cnt : '0;

endmodule

// File: tb/tb_gesture_sampler.sv
// Directed vector table, reset corner case, then random frames against a queue-based model.
module tb_gesture_sampler;

  localparam int ST = 4, CD = 8, RL = 2, TO = 20;
  localparam logic [1:0] GS = 2'b00, GP = 2'b01, GR = 2'b10, GN = 2'b11;

  logic       clk = 1'b0;
  logic       reset, frame_done;
  logic [1:0] raw_gesture, player_gesture;
  logic       valid, go, capture_timeout, countdown_active;
  logic [7:0] frames_left;

  int n_chk = 0, n_err = 0;

  always #5 clk = ~clk;

  gesture_sampler #(
    .STABLE_FRAMES(ST), .COUNTDOWN_FRAMES(CD), .RELEASE_FRAMES(RL), .TIMEOUT_FRAMES(TO)
  ) dut (
    .clk(clk), .reset(reset), .frame_done(frame_done), .raw_gesture(raw_gesture),
    .player_gesture(player_gesture), .valid(valid), .go(go),
    .capture_timeout(capture_timeout), .countdown_active(countdown_active),
    .frames_left(frames_left)
  );

  typedef struct {
    logic [1:0] g;
    logic       v, go, to;
    logic [1:0] pg;
    logic       ca;
    int         fl;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  task automatic add(input logic [1:0] g, input logic v, input logic gg, input logic to,
                     input logic [1:0] pg, input logic ca, input int fl);
    vec_t e;
    e.g = g; e.v = v; e.go = gg; e.to = to; e.pg = pg; e.ca = ca; e.fl = fl;
    tbl.push_back(e);
  endtask

  task automatic add_countdown(input logic [1:0] pg);
    for (int i = 1; i < CD; i++) add(GN, 0, 0, 0, pg, 1, CD - i);
    add(GN, 0, 1, 0, pg, 0, 0);
  endtask

  // One frame_done cycle; returns on the falling edge after the registering edge.
  task automatic do_frame(input logic [1:0] g);
    @(negedge clk);
    frame_done  = 1'b1;
    raw_gesture = g;
    @(negedge clk);
    frame_done  = 1'b0;
    raw_gesture = 2'($urandom);
  endtask

  task automatic check_outputs(input string tag, input logic v, input logic gg, input logic to,
                               input logic [1:0] pg, input logic ca, input int fl);
    chk({tag, ".valid"}, int'(valid), int'(v));
    chk({tag, ".go"}, int'(go), int'(gg));
    chk({tag, ".timeout"}, int'(capture_timeout), int'(to));
    chk({tag, ".player_gesture"}, int'(player_gesture), int'(pg));
    chk({tag, ".countdown_active"}, int'(countdown_active), int'(ca));
    chk({tag, ".frames_left"}, int'(frames_left), fl);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1; frame_done = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  // Reference model: frame-level history queues, not a cycle model.
  int         m_ph;     // 0 countdown, 1 capture, 2 release
  int         m_left;
  logic [1:0] m_pg;
  logic [1:0] cap_hist[$];
  logic [1:0] rel_hist[$];

  function automatic void model_reset();
    m_ph = 0; m_left = CD; m_pg = GN;
    cap_hist.delete(); rel_hist.delete();
  endfunction

  function automatic int trailing_run(input logic [1:0] q[$]);
    int n = 0;
    logic [1:0] last;
    if (q.size() == 0) return 0;
    last = q[q.size()-1];
    if (last == GN) return 0;
    for (int i = q.size() - 1; i >= 0 && q[i] == last; i--) n++;
    return n;
  endfunction

  function automatic int trailing_none(input logic [1:0] q[$]);
    int n = 0;
    for (int i = q.size() - 1; i >= 0 && q[i] == GN; i--) n++;
    return n;
  endfunction

  function automatic void model_frame(input logic [1:0] g, output logic ev, output logic eg,
                                      output logic et);
    ev = 0; eg = 0; et = 0;
    if (m_ph == 0) begin
      m_left--;
      if (m_left == 0) begin eg = 1; m_ph = 1; cap_hist.delete(); end
    end else if (m_ph == 1) begin
      cap_hist.push_back(g);
      if (trailing_run(cap_hist) >= ST) begin
        ev = 1; m_pg = g; m_ph = 2; rel_hist.delete();
      end else if (cap_hist.size() == TO) begin
        et = 1; m_ph = 0; m_left = CD;
      end
    end else begin
      rel_hist.push_back(g);
      if (trailing_none(rel_hist) >= RL) begin m_ph = 0; m_left = CD; end
    end
  endfunction

  initial begin
    logic [1:0] g, prev;
    logic ev, eg, et;

    reset = 1'b1; frame_done = 1'b0; raw_gesture = GN;

    // Countdown, lock after a candidate switch, release with a glitch, lock after a
    // none gap, pure timeout, and lock on the timeout frame.
    add_countdown(GN);
    add(GR, 0, 0, 0, GN, 0, 0); add(GR, 0, 0, 0, GN, 0, 0);
    add(GP, 0, 0, 0, GN, 0, 0); add(GP, 0, 0, 0, GN, 0, 0); add(GP, 0, 0, 0, GN, 0, 0);
    add(GP, 1, 0, 0, GP, 0, 0);
    add(GN, 0, 0, 0, GP, 0, 0); add(GR, 0, 0, 0, GP, 0, 0);
    add(GN, 0, 0, 0, GP, 0, 0); add(GN, 0, 0, 0, GP, 1, CD);
    add_countdown(GP);
    add(GR, 0, 0, 0, GP, 0, 0); add(GR, 0, 0, 0, GP, 0, 0); add(GN, 0, 0, 0, GP, 0, 0);
    add(GR, 0, 0, 0, GP, 0, 0); add(GR, 0, 0, 0, GP, 0, 0); add(GR, 0, 0, 0, GP, 0, 0);
    add(GR, 1, 0, 0, GR, 0, 0);
    add(GN, 0, 0, 0, GR, 0, 0); add(GN, 0, 0, 0, GR, 1, CD);
    add_countdown(GR);
    for (int i = 0; i < TO - 1; i++) add((i % 2 == 0) ? GR : GP, 0, 0, 0, GR, 0, 0);
    add(GP, 0, 0, 1, GR, 1, CD);
    add_countdown(GR);
    for (int i = 0; i < TO - ST; i++) add((i % 2 == 0) ? GR : GP, 0, 0, 0, GR, 0, 0);
    for (int i = 0; i < ST - 1; i++) add(GS, 0, 0, 0, GR, 0, 0);
    add(GS, 1, 0, 0, GS, 0, 0);
    add(GN, 0, 0, 0, GS, 0, 0); add(GN, 0, 0, 0, GS, 1, CD);

    do_reset();
    check_outputs("reset", 0, 0, 0, GN, 1, CD);

    foreach (tbl[i]) begin
      do_frame(tbl[i].g);
      check_outputs($sformatf("vec%0d", i), tbl[i].v, tbl[i].go, tbl[i].to, tbl[i].pg,
                    tbl[i].ca, tbl[i].fl);
      @(negedge clk);
      chk($sformatf("vec%0d.pulse_width", i), int'({valid, go, capture_timeout}), 0);
    end

    // Reset coinciding with the frame that would complete a run of ST.
    add_countdown(GN);
    for (int i = 0; i < CD; i++) do_frame(GN);
    for (int i = 0; i < ST - 1; i++) do_frame(GR);
    @(negedge clk);
    reset = 1'b1; frame_done = 1'b1; raw_gesture = GR;
    @(negedge clk);
    frame_done = 1'b0;
    check_outputs("mid_capture_reset", 0, 0, 0, GN, 1, CD);
    reset = 1'b0;
    @(negedge clk);
    check_outputs("after_reset", 0, 0, 0, GN, 1, CD);
    do_frame(GR);
    check_outputs("post_reset_frame", 0, 0, 0, GN, 1, CD - 1);

    // Random frames with idle gaps, compared against the model after every frame.
    do_reset();
    model_reset();
    prev = GR;
    for (int i = 0; i < 600; i++) begin
      g = ($urandom_range(0, 9) < 6) ? prev : 2'($urandom_range(0, 3));
      prev = g;
      do_frame(g);
      model_frame(g, ev, eg, et);
      check_outputs($sformatf("rnd%0d", i), ev, eg, et, m_pg, (m_ph == 0),
                    (m_ph == 0) ? m_left : 0);
      repeat ($urandom_range(0, 2)) begin
        @(negedge clk);
        chk($sformatf("rnd%0d.idle_pulse", i), int'({valid, go, capture_timeout}), 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
